// File: rtl/ula_multiciclo.sv
// ula_multiciclo: EX-stage ALU with a start/busy/done handshake.
// Logic and arithmetic ops complete in one cycle. Shifts run one bit per cycle
// through a shift register unless BARREL_SHIFT_EN is defined, in which case a
// combinational barrel shifter makes every op a one-cycle op.
// Result, zero and illegal are registered and held until the next done pulse.
module ula_multiciclo #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      ula_select,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_AND  = 4'd10;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]    XZERO    = {XLEN{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state_r;
    logic [XLEN-1:0]     shreg_r;
    logic [SHAMT_W-1:0]  count_r;
    logic [3:0]          op_r;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;
    logic                zero_r;
    logic                illegal_r;

    logic [SHAMT_W-1:0]  shamt_s;
    logic [XLEN-1:0]     alu_s;
    logic                illegal_s;
    logic                is_shift_s;
    logic                start_iter_s;
    logic [XLEN-1:0]     shift_next_s;

    assign shamt_s = b[SHAMT_W-1:0];

    // Single-cycle datapath; iterative-build shifts yield a here (the shamt=0 case).
    always_comb begin
        alu_s      = XZERO;
        illegal_s  = 1'b0;
        is_shift_s = 1'b0;
        case (ula_select)
            OP_ADD:  alu_s = a + b;
            OP_SUB:  alu_s = a - b;
            OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_s = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  alu_s = a ^ b;
            OP_OR:   alu_s = a | b;
            OP_AND:  alu_s = a & b;
`ifdef BARREL_SHIFT_EN
            OP_SLL: begin
                is_shift_s = 1'b1;
                alu_s      = a << shamt_s;
            end
            OP_SRL: begin
                is_shift_s = 1'b1;
                alu_s      = a >> shamt_s;
            end
            OP_SRA: begin
                is_shift_s = 1'b1;
                alu_s      = $signed(a) >>> shamt_s;
            end
`else
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift_s = 1'b1;
                alu_s      = a;
            end
`endif
            default: begin
                illegal_s = 1'b1;
                alu_s     = XZERO;
            end
        endcase
    end

    // Decide whether an accepted op needs the multi-cycle SHIFT state.
    always_comb begin
`ifdef BARREL_SHIFT_EN
        start_iter_s = 1'b0;
`else
        if (is_shift_s && (shamt_s != CNT_ZERO)) begin
            start_iter_s = 1'b1;
        end else begin
            start_iter_s = 1'b0;
        end
`endif
    end

    // One-bit shift step; SRA replicates the MSB, which is the sign of the latched a.
    always_comb begin
        shift_next_s = shreg_r;
        case (op_r)
            OP_SLL:  shift_next_s = {shreg_r[XLEN-2:0], 1'b0};
            OP_SRL:  shift_next_s = {1'b0, shreg_r[XLEN-1:1]};
            OP_SRA:  shift_next_s = {shreg_r[XLEN-1], shreg_r[XLEN-1:1]};
            default: shift_next_s = shreg_r;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            shreg_r   <= XZERO;
            count_r   <= CNT_ZERO;
            op_r      <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= XZERO;
            zero_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (start_iter_s) begin
                            shreg_r <= a;
                            count_r <= shamt_s;
                            op_r    <= ula_select;
                            busy_r  <= 1'b1;
                            state_r <= ST_SHIFT;
                        end else begin
                            result_r  <= alu_s;
                            zero_r    <= (alu_s == XZERO);
                            illegal_r <= illegal_s;
                            done_r    <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= shift_next_s;
                    count_r <= count_r - CNT_ONE;
                    if (count_r == CNT_ONE) begin
                        result_r  <= shift_next_s;
                        zero_r    <= (shift_next_s == XZERO);
                        illegal_r <= 1'b0;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign zero    = zero_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: the driver pushes expected responses,
// an independent monitor pops and compares on every done pulse.
module tb_ula_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ula_select = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, zero, illegal;
    logic [31:0] result;

    ula_multiciclo #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ula_select(ula_select),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: plain arithmetic on the op code; returns {illegal, result}.
    function automatic logic [32:0] ref_op(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        logic [31:0] r;
        sh = y % 32;
        case (sel)
            4'd1:    r = x + y;
            4'd2:    r = x - y;
            4'd3:    r = x << sh;
            4'd4:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd5:    r = (x < y) ? 32'd1 : 32'd0;
            4'd6:    r = x >> sh;
            4'd7:    r = 32'($signed(x) >>> sh);
            4'd8:    r = x ^ y;
            4'd9:    r = x | y;
            4'd10:   r = x & y;
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic int lat_of(input logic [3:0] sel, input logic [31:0] y);
`ifdef BARREL_SHIFT_EN
        return 1;
`else
        if ((sel == 4'd3 || sel == 4'd6 || sel == 4'd7) && (y % 32) != 0) return int'(y % 32) + 1;
        return 1;
`endif
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("zero", {31'd0, zero}, {31'd0, (e.res == 32'd0)});
                check("illegal", {31'd0, illegal}, {31'd0, e.ill});
                check("latency", cyc, e.due);
            end
        end
    end

    // Drive one start pulse at the current negedge and record the expectation.
    task automatic issue(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] res, input logic ill, output int lat);
        exp_t e;
        ula_select = sel;
        a = x;
        b = y;
        start = 1'b1;
        lat = lat_of(sel, y);
        e.res = res;
        e.ill = ill;
        e.due = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        ula_select = 4'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    // Wait for done, counting busy cycles; optionally pulse an ADD start mid-shift.
    task automatic wait_done(input int lat, input bit poke);
        int n;
        int bc;
        bc = 0;
        for (n = 0; n < 100; n++) begin
            if (done === 1'b1) break;
            if (busy === 1'b1) bc++;
            if (poke && n == 0 && lat >= 3) begin
                start = 1'b1;
                ula_select = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (n == 100) begin
            checks++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        check("busy_cycles", bc, lat - 1);
    endtask

    task automatic dop(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] res, input logic ill, input bit poke);
        int lat;
        issue(sel, x, y, res, ill, lat);
        wait_done(lat, poke);
    endtask

    task automatic rop(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y, input bit poke);
        logic [32:0] m;
        m = ref_op(sel, x, y);
        dop(sel, x, y, m[31:0], m[32], poke);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        dop(4'd1, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        dop(4'd2, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
        dop(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        dop(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
        dop(4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1);
        dop(4'd3, 32'd1, 32'h23, 32'd8, 1'b0, 1'b0);
        dop(4'd6, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1'b0);

        // Reset in the middle of a long shift: no done may follow.
        issue(4'd3, 32'd1, 32'd20, 32'h0010_0000, 1'b0, lat);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd0);
        check("midrst_illegal", {31'd0, illegal}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        dop(4'hF, $urandom, $urandom, 32'd0, 1'b1, 1'b0);
        dop(4'h0, $urandom, $urandom, 32'd0, 1'b1, 1'b0);
        rop(4'd8, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  s;
            logic [31:0] x, y;
            s = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            rop(s, x, y, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
